// File: rtl/free_list_pkg.sv
// Shared rename-stage types and sizing for the physical register free list.
// Provides: phys_reg_t (physical tag), free_list_ptr_t (index + wrap bit),
// the register-count constants, and a pointer increment helper.
package free_list_pkg;

  localparam int NUM_PHYS_REGS   = 64;
  localparam int NUM_ARCH_REGS   = 32;
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

  localparam int PREG_W   = $clog2(NUM_PHYS_REGS);
  localparam int FL_IDX_W = $clog2(FREE_LIST_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0]   phys_reg_t;
  typedef logic [FL_PTR_W-1:0] free_list_ptr_t;

  // Pointers wrap naturally modulo 2^FL_PTR_W.
  function automatic free_list_ptr_t ptr_inc(input free_list_ptr_t p);
    return p + free_list_ptr_t'(1);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/commit <-> free list handshake bundle.
// master: rename/commit side (drives alloc_req, free_req/free_preg, commit_alloc, flush).
// slave:  free list (drives alloc_valid, alloc_preg, count, empty, full).
interface free_list_if;
  import free_list_pkg::*;

  logic           alloc_req;
  logic           alloc_valid;
  phys_reg_t      alloc_preg;
  logic           free_req;
  phys_reg_t      free_preg;
  logic           commit_alloc;
  logic           flush;
  free_list_ptr_t count;
  logic           empty;
  logic           full;

  modport master (
    output alloc_req, free_req, free_preg, commit_alloc, flush,
    input  alloc_valid, alloc_preg, count, empty, full
  );

  modport slave (
    input  alloc_req, free_req, free_preg, commit_alloc, flush,
    output alloc_valid, alloc_preg, count, empty, full
  );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with a speculative head and a
// retire head, so a flush rolls back speculative allocations in one cycle.
// Ports: clk, rst (async active-high), bus (free_list_if.slave).
module free_list
  import free_list_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  free_list_if.slave   bus
);

  localparam free_list_ptr_t FULL_COUNT = free_list_ptr_t'(FREE_LIST_DEPTH);

  phys_reg_t      mem [FREE_LIST_DEPTH];
  free_list_ptr_t spec_head;
  free_list_ptr_t retire_head;
  free_list_ptr_t tail;

  free_list_ptr_t count_w;
  logic           empty_w;
  logic           pop;

  // Occupancy is measured from the speculative head; the wrap bit makes the
  // 6-bit difference reach exactly DEPTH when full.
  assign count_w = tail - spec_head;
  assign empty_w = (count_w == '0);

  assign bus.count       = count_w;
  assign bus.empty       = empty_w;
  assign bus.full        = (count_w == FULL_COUNT);
  // flush is the only input that reaches an output combinationally.
  assign bus.alloc_valid = !empty_w && !bus.flush;
  assign bus.alloc_preg  = mem[spec_head[FL_IDX_W-1:0]];

  // alloc_valid already excludes flush, so a pop racing a flush is dropped.
  assign pop = bus.alloc_req && bus.alloc_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head   <= '0;
      retire_head <= '0;
      tail        <= FULL_COUNT;
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        mem[i] <= phys_reg_t'(NUM_ARCH_REGS + i);
      end
    end else begin
      // Recover to the committed position, including a commit in this cycle.
      if (bus.flush) begin
        spec_head <= retire_head + {{(FL_PTR_W-1){1'b0}}, bus.commit_alloc};
      end else if (pop) begin
        spec_head <= ptr_inc(spec_head);
      end

      if (bus.commit_alloc) begin
        retire_head <= ptr_inc(retire_head);
      end

      // No bypass: the pushed tag becomes visible after this edge.
      if (bus.free_req) begin
        mem[tail[FL_IDX_W-1:0]] <= bus.free_preg;
        tail                    <= ptr_inc(tail);
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(bus.free_req && bus.full));

  a_no_retire_past_spec: assert property (@(posedge clk) disable iff (rst)
    !(bus.commit_alloc && (retire_head == spec_head) && !pop));

  a_no_free_arch_tag: assert property (@(posedge clk) disable iff (rst)
    !(bus.free_req && (bus.free_preg < phys_reg_t'(NUM_ARCH_REGS))));
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table for drain/refill, hand
// sequences for flush and async reset, scoreboard for wrap-around traffic.
// Ports: none (top-level bench).
module tb_free_list;
  import free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  free_list_if bus ();

  free_list dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic      alloc_req;
    logic      free_req;
    phys_reg_t free_preg;
    logic      exp_valid;
    logic      chk_preg;
    phys_reg_t exp_preg;
    int        exp_count;
    logic      exp_empty;
    logic      exp_full;
  } vec_t;

  vec_t      vecs[$];
  phys_reg_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic areq, input logic freq, input phys_reg_t fpreg,
                       input logic commit, input logic fl);
    bus.alloc_req    = areq;
    bus.free_req     = freq;
    bus.free_preg    = fpreg;
    bus.commit_alloc = commit;
    bus.flush        = fl;
  endtask

  // Drive at the falling edge and sample 2 ns later, well before the rising edge.
  task automatic cycle(input logic areq, input logic freq, input phys_reg_t fpreg,
                       input logic commit, input logic fl);
    @(negedge clk);
    drive(areq, freq, fpreg, commit, fl);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic areq, input logic freq, input phys_reg_t fp,
                              input logic ev, input logic cp, input phys_reg_t ep,
                              input int ec, input logic ee, input logic ef);
    vec_t v;
    v.alloc_req = areq; v.free_req = freq; v.free_preg = fp;
    v.exp_valid = ev;   v.chk_preg = cp;   v.exp_preg  = ep;
    v.exp_count = ec;   v.exp_empty = ee;  v.exp_full  = ef;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("reset_count_in_reset", bus.count, 32);
    check("reset_full_in_reset", bus.full, 1);
    check("reset_preg_in_reset", bus.alloc_preg, 32);
    @(negedge clk);
    rst = 1'b0;

    // ---- Drain 32 tags, overrun, then refill with no bypass ----
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 1'b1, phys_reg_t'(32 + i), 32 - i, 1'b0, i == 0));
    vecs.push_back(mk(1'b1, 1'b0, '0,            1'b0, 1'b0, '0,            0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, '0,            1'b0, 1'b0, '0,            0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, phys_reg_t'(40), 1'b0, 1'b0, '0,          0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, '0,            1'b1, 1'b1, phys_reg_t'(40), 1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, '0,            1'b0, 1'b0, '0,            0, 1'b1, 1'b0));

    foreach (vecs[k]) begin
      cycle(vecs[k].alloc_req, vecs[k].free_req, vecs[k].free_preg, 1'b0, 1'b0);
      check($sformatf("vec%0d_valid", k), bus.alloc_valid, vecs[k].exp_valid);
      if (vecs[k].chk_preg) check($sformatf("vec%0d_preg", k), bus.alloc_preg, vecs[k].exp_preg);
      check($sformatf("vec%0d_count", k), bus.count, vecs[k].exp_count);
      check($sformatf("vec%0d_empty", k), bus.empty, vecs[k].exp_empty);
      check($sformatf("vec%0d_full", k), bus.full, vecs[k].exp_full);
    end

    // ---- Pop 5, retire 2, flush back to the third tag ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("spec_pop_preg", bus.alloc_preg, 32 + i);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("pre_flush_count", bus.count, 27);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("flush_blocks_valid", bus.alloc_valid, 0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("flush_preg", bus.alloc_preg, 34);
    check("flush_count", bus.count, 30);

    // ---- Flush + commit + push + pop in one cycle ----
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, phys_reg_t'(33), 1'b1, 1'b1);
    check("combo_valid_low", bus.alloc_valid, 0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("combo_count", bus.count, 32);
    check("combo_preg", bus.alloc_preg, 33);
    check("combo_full", bus.full, 1);
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("combo_drain_preg", bus.alloc_preg, 33 + i);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("combo_old_tail_preg", bus.alloc_preg, 33);
    check("combo_old_tail_count", bus.count, 1);

    // ---- Random interleaved traffic across the pointer wrap ----
    do_reset();
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back(phys_reg_t'(32 + i));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("wrap_warm_preg", bus.alloc_preg, sb.pop_front());
    end
    for (int i = 0; i < 100; i++) begin
      logic      do_pop, do_push;
      phys_reg_t tag;
      do_pop  = (sb.size() > 1)  && ($urandom_range(0, 1) == 1);
      do_push = (sb.size() < 31) && ($urandom_range(0, 1) == 1);
      tag     = phys_reg_t'(32 + $urandom_range(0, 31));
      cycle(do_pop, do_push, tag, 1'b0, 1'b0);
      check("wrap_count", bus.count, sb.size());
      if (do_pop) begin
        check("wrap_valid", bus.alloc_valid, 1);
        check("wrap_preg", bus.alloc_preg, sb.pop_front());
      end
      if (do_push) sb.push_back(tag);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("wrap_final_count", bus.count, sb.size());

    // ---- Asynchronous reset between clock edges ----
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("pre_arst_count", bus.count, 28);
    rst = 1'b1;
    #1;
    check("arst_count", bus.count, 32);
    check("arst_preg", bus.alloc_preg, 32);
    check("arst_full", bus.full, 1);
    #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register tags for the rename stage of the out-of-order core. It sits directly upstream of the rename/RAT logic and hands out a free destination tag (`rat_rd`) for every renamed instruction that writes a register. Commit returns each superseded tag to it. A retire-side head pointer lets it roll back speculative allocations in one cycle on a pipeline flush.

## Interface
- `NUM_PHYS_REGS`, default 64: physical register count; tag width is clog2 = 6.
- `NUM_ARCH_REGS`, default 32: architectural registers; tags 0..31 are mapped at reset.
- `DEPTH`, default `NUM_PHYS_REGS - NUM_ARCH_REGS` = 32: FIFO entries (power of two).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alloc_req` in 1: rename pops one tag this cycle.
- `alloc_valid` out 1: a tag is available; a pop happens on `alloc_req && alloc_valid`.
- `alloc_preg` out 6: tag at the speculative head (combinational). Don't-care when `!alloc_valid`.
- `free_req` in 1: commit pushes a freed tag.
- `free_preg` in 6: tag being freed.
- `commit_alloc` in 1: the committing instruction had a destination, so the retire head advances by one.
- `flush` in 1: misprediction rollback.
- `count` out 6: free entries relative to the speculative head, 0..32.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.

## Operation
- Storage: `DEPTH` × 6-bit entries.
- Three pointers, each `clog2(DEPTH)+1` = 6 bits (index plus wrap bit):
  - `spec_head`: next tag to allocate.
  - `retire_head`: next tag to be committed.
  - `tail`: next write slot.
- Reset (async):
  - Entry i = `NUM_ARCH_REGS + i` (p32..p63).
  - `spec_head = retire_head = 0`, `tail = 6'b100000`.
  - Outputs after reset: `count = 32`, `full = 1`, `empty = 0`, `alloc_valid = 1`, `alloc_preg = 32`.
- Pop: if `alloc_req && alloc_valid && !flush`, then `spec_head` += 1.
- Push: if `free_req`, then `mem[tail idx] <= free_preg` and `tail` += 1.
- Retire: if `commit_alloc`, then `retire_head` += 1.
- Flush: `spec_head <= retire_head + commit_alloc`. Any pop in the same cycle is dropped. Push and retire in the same cycle still take effect, because commit is non-speculative.
- Arithmetic:
  - Pointers increment modulo 2^6.
  - `count = tail - spec_head`, 6-bit unsigned.
  - Full is `count == 32`: index bits equal, wrap bits differ.
- `alloc_valid = !empty && !flush`.
- No bypass: a tag pushed in cycle N is allocatable from cycle N+1. While empty, a same-cycle push does not raise `alloc_valid`.
- Illegal conditions (simulation assertions; RTL behaviour undefined):
  - push while `full`;
  - `commit_alloc` when `retire_head == spec_head` with no same-cycle pop;
  - `free_preg < NUM_ARCH_REGS` while `free_req` is high.
- No state machine beyond the pointers; the pointer triple is the state.

## Timing
- `alloc_preg`, `alloc_valid`, `empty`, `full`, `count` are combinational from registered pointers and storage. No input-to-output combinational path, except `flush` to `alloc_valid`.
- Pop latency 0: the tag is valid in the same cycle as `alloc_req`. The next tag appears after the clock edge.
- Push-to-available latency: 1 cycle.
- Flush: recovered `count` and `alloc_preg` are visible the cycle after `flush`.
- `rst` asserted mid-operation returns every register to its reset value immediately, independent of `clk`.

## Structure
- Shared package additions:
  - `phys_reg_t` (`logic [5:0]`);
  - constants `NUM_PHYS_REGS`, `NUM_ARCH_REGS`, `FREE_LIST_DEPTH`;
  - `free_list_ptr_t` (`logic [5:0]`).
- Single flat module. No sub-module; a generic FIFO does not fit because of the dual head.

## Test plan
- Reset, then 32 consecutive pops -> tags 32..63 in order; `empty = 1` and `alloc_valid = 0` after the 32nd pop; a 33rd `alloc_req` leaves `spec_head` unchanged.
- Drain to empty, then push tag 40 with `alloc_req` held high -> `alloc_valid = 0` that cycle; next cycle `alloc_preg = 40`, pop succeeds.
- Pop 5 (tags 32..36), `commit_alloc` twice, then `flush` -> next cycle `alloc_preg = 34`, `count = 30`.
- `flush`, `commit_alloc`, `free_req`(tag 7 illegal → use tag 33), and `alloc_req` in the same cycle after 3 pops -> pop dropped; `spec_head = retire_head + 1`; `count` increases by 1 from the push; tag 33 written at the old tail.
- Wrap-around: 100 random interleaved pop/push cycles keeping occupancy 1..31 -> pop order equals push order across the pointer wrap; `count` matches the scoreboard.
- Assert `rst` asynchronously between edges mid-stream -> `count = 32`, `alloc_preg = 32` immediately, before the next `clk` edge.
